// File: rtl/out_reg_demux16.sv
// out_reg_demux16
// Write-side steering of LSU stores into 16 memory-mapped output registers
// (LEDs, HEX displays, other output peripherals). A store is accepted into a
// one-entry commit stage by a valid/ready handshake. It then commits into the
// selected register under byte enables unless freeze_i holds it. A registered
// read-back port returns any register one cycle later, and it includes a write
// that commits on the same edge.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wr_valid_i/wr_ready_o store handshake
//   wr_sel_i/data/be      destination index, data, byte enables
//   freeze_i              hold the staged write (no commit)
//   rd_sel_i/rd_data_o    read-back index and registered data
//   q_o                   all 16 registers flattened, reg n at [32n+31:32n]
//   wr_done_o             one-cycle pulse after a commit edge
//   commit_cnt_o          wrapping count of commits since reset
module out_reg_demux16 #(
    parameter int              DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = 32'h0000_0000,
    parameter int              CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [3:0]           wr_sel_i,
    input  logic [DATA_W-1:0]    wr_data_i,
    input  logic [3:0]           wr_be_i,
    input  logic                 freeze_i,
    input  logic [3:0]           rd_sel_i,
    output logic [DATA_W-1:0]    rd_data_o,
    output logic [16*DATA_W-1:0] q_o,
    output logic                 wr_done_o,
    output logic [CNT_W-1:0]     commit_cnt_o
);

    logic [DATA_W-1:0] regs [16];

    logic              stg_vld;
    logic [3:0]        stg_sel;
    logic [DATA_W-1:0] stg_data;
    logic [3:0]        stg_be;

    logic              commit;
    logic              xfer;
    logic [DATA_W-1:0] merged;

    assign commit     = stg_vld & ~freeze_i;
    // An entry that commits this edge frees the stage, so accept a new one
    // on the same edge to sustain one write per cycle.
    assign wr_ready_o = ~stg_vld | ~freeze_i;
    assign xfer       = wr_valid_i & wr_ready_o;

    // New value of the target register after applying the byte enables.
    always_comb begin
        merged = regs[stg_sel];
        for (int k = 0; k < 4; k++) begin
            if (stg_be[k]) begin
                merged[8*k +: 8] = stg_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        q_o = '0;
        for (int n = 0; n < 16; n++) begin
            q_o[n*DATA_W +: DATA_W] = regs[n];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < 16; n++) begin
                regs[n] <= RST_VAL;
            end
            stg_vld      <= 1'b0;
            stg_sel      <= '0;
            stg_data     <= '0;
            stg_be       <= '0;
            wr_done_o    <= 1'b0;
            commit_cnt_o <= '0;
            rd_data_o    <= RST_VAL;
        end else begin
            wr_done_o <= commit;
            if (commit) begin
                regs[stg_sel] <= merged;
                commit_cnt_o  <= commit_cnt_o + 1'b1;
            end

            if (xfer) begin
                stg_vld  <= 1'b1;
                stg_sel  <= wr_sel_i;
                stg_data <= wr_data_i;
                stg_be   <= wr_be_i;
            end else if (commit) begin
                stg_vld <= 1'b0;
            end

            // Write-first: a read of the register committing on this edge
            // returns the new contents.
            if (commit && (stg_sel == rd_sel_i)) begin
                rd_data_o <= merged;
            end else begin
                rd_data_o <= regs[rd_sel_i];
            end
        end
    end

endmodule

// File: tb/tb_out_reg_demux16.sv
module tb_out_reg_demux16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [3:0]  wr_sel_i;
    logic [31:0] wr_data_i;
    logic [3:0]  wr_be_i;
    logic        freeze_i;
    logic [3:0]  rd_sel_i;
    logic [31:0] rd_data_o;
    logic [511:0] q_o;
    logic        wr_done_o;
    logic [15:0] commit_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    out_reg_demux16 dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_sel_i     (wr_sel_i),
        .wr_data_i    (wr_data_i),
        .wr_be_i      (wr_be_i),
        .freeze_i     (freeze_i),
        .rd_sel_i     (rd_sel_i),
        .rd_data_o    (rd_data_o),
        .q_o          (q_o),
        .wr_done_o    (wr_done_o),
        .commit_cnt_o (commit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_at(input int n);
        return q_o[n*32 +: 32];
    endfunction

    // Advance one rising edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i      = 1'b1;
        wr_valid_i = 1'b0;
        wr_sel_i   = '0;
        wr_data_i  = '0;
        wr_be_i    = '0;
        freeze_i   = 1'b0;
        rd_sel_i   = '0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Reset state
        for (int n = 0; n < 16; n++) chk($sformatf("rst_reg%0d", n), reg_at(n), 32'h0);
        chk("rst_rd", rd_data_o, 32'h0);
        chk("rst_ready", {31'b0, wr_ready_o}, 32'h1);
        chk("rst_cnt", {16'b0, commit_cnt_o}, 32'h0);
        chk("rst_done", {31'b0, wr_done_o}, 32'h0);

        // Single write to reg5
        wr_valid_i = 1'b1; wr_sel_i = 4'd5; wr_data_i = 32'hDEADBEEF; wr_be_i = 4'hF;
        tick();
        wr_valid_i = 1'b0;
        chk("w5_staged_done", {31'b0, wr_done_o}, 32'h0);
        chk("w5_staged_reg", reg_at(5), 32'h0);
        tick();
        chk("w5_reg", reg_at(5), 32'hDEADBEEF);
        chk("w5_done", {31'b0, wr_done_o}, 32'h1);
        chk("w5_cnt", {16'b0, commit_cnt_o}, 32'h1);
        for (int n = 0; n < 16; n++)
            if (n != 5) chk($sformatf("w5_other%0d", n), reg_at(n), 32'h0);
        tick();
        chk("w5_done_end", {31'b0, wr_done_o}, 32'h0);

        // Back-to-back writes to reg3 with partial byte enables
        wr_valid_i = 1'b1; wr_sel_i = 4'd3; wr_data_i = 32'h11111111; wr_be_i = 4'hF;
        chk("b2b_ready0", {31'b0, wr_ready_o}, 32'h1);
        tick();
        wr_data_i = 32'h22220000; wr_be_i = 4'b1100;
        chk("b2b_ready1", {31'b0, wr_ready_o}, 32'h1);
        tick();
        wr_valid_i = 1'b0;
        chk("b2b_ready2", {31'b0, wr_ready_o}, 32'h1);
        chk("b2b_first", reg_at(3), 32'h11111111);
        chk("b2b_done1", {31'b0, wr_done_o}, 32'h1);
        tick();
        chk("b2b_reg3", reg_at(3), 32'h22221111);
        chk("b2b_done2", {31'b0, wr_done_o}, 32'h1);
        chk("b2b_cnt", {16'b0, commit_cnt_o}, 32'd3);   // 1 earlier + 2 here
        tick();
        chk("b2b_done_end", {31'b0, wr_done_o}, 32'h0);

        // Freeze with a staged write and a second request pending
        wr_valid_i = 1'b1; wr_sel_i = 4'd7; wr_data_i = 32'hA5A5A5A5; wr_be_i = 4'hF;
        tick();
        freeze_i = 1'b1;
        wr_sel_i = 4'd8; wr_data_i = 32'h08080808;
        #1;
        chk("frz_ready_pre", {31'b0, wr_ready_o}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("frz_ready%0d", i), {31'b0, wr_ready_o}, 32'h0);
            chk($sformatf("frz_done%0d", i), {31'b0, wr_done_o}, 32'h0);
            chk($sformatf("frz_reg7_%0d", i), reg_at(7), 32'h0);
        end
        freeze_i = 1'b0;
        #1;
        chk("frz_release_ready", {31'b0, wr_ready_o}, 32'h1);
        tick();
        wr_valid_i = 1'b0;
        chk("frz_reg7", reg_at(7), 32'hA5A5A5A5);
        chk("frz_done", {31'b0, wr_done_o}, 32'h1);
        chk("frz_cnt", {16'b0, commit_cnt_o}, 32'd4);
        tick();
        chk("frz_reg8", reg_at(8), 32'h08080808);
        chk("frz_cnt2", {16'b0, commit_cnt_o}, 32'd5);

        // Read-back bypass on the commit edge, then a plain read
        wr_valid_i = 1'b1; wr_sel_i = 4'd9; wr_data_i = 32'h0000CAFE; wr_be_i = 4'hF;
        tick();
        wr_valid_i = 1'b0;
        rd_sel_i   = 4'd9;
        tick();
        chk("byp_rd", rd_data_o, 32'h0000CAFE);
        chk("byp_cnt", {16'b0, commit_cnt_o}, 32'd6);
        rd_sel_i = 4'd3;
        tick();
        chk("rd_reg3", rd_data_o, 32'h22221111);

        // Reset while a frozen write sits in the stage
        wr_valid_i = 1'b1; wr_sel_i = 4'd2; wr_data_i = 32'h12345678; wr_be_i = 4'hF;
        tick();
        wr_valid_i = 1'b0;
        freeze_i   = 1'b1;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i    = 1'b0;
        freeze_i = 1'b0;
        chk("mrst_reg2", reg_at(2), 32'h0);
        chk("mrst_reg7", reg_at(7), 32'h0);
        chk("mrst_cnt", {16'b0, commit_cnt_o}, 32'h0);
        chk("mrst_done", {31'b0, wr_done_o}, 32'h0);
        chk("mrst_rd", rd_data_o, 32'h0);
        chk("mrst_ready", {31'b0, wr_ready_o}, 32'h1);
        tick();
        chk("mrst_reg2_after", reg_at(2), 32'h0);
        chk("mrst_done_after", {31'b0, wr_done_o}, 32'h0);
        chk("mrst_cnt_after", {16'b0, commit_cnt_o}, 32'h0);

        // Preload the counter to 0xFFFF with be=0 writes (no data change).
        // K edges of continuous valid give K-1 commits plus one final drain.
        wr_valid_i = 1'b1; wr_sel_i = 4'd0; wr_data_i = 32'hFFFFFFFF; wr_be_i = 4'h0;
        repeat (65535) @(posedge clk_i);
        #1;
        wr_valid_i = 1'b0;
        tick();
        chk("pre_cnt", {16'b0, commit_cnt_o}, 32'h0000FFFF);
        chk("pre_reg0", reg_at(0), 32'h0);
        chk("pre_done", {31'b0, wr_done_o}, 32'h1);

        // Wrapping commit, low byte only
        wr_valid_i = 1'b1; wr_sel_i = 4'd1; wr_data_i = 32'hFFFFFFFF; wr_be_i = 4'b0001;
        tick();
        wr_valid_i = 1'b0;
        tick();
        chk("wrap_cnt", {16'b0, commit_cnt_o}, 32'h0);
        chk("wrap_done", {31'b0, wr_done_o}, 32'h1);
        chk("wrap_reg1", reg_at(1), 32'h000000FF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/out_reg_demux16.md
Name: out_reg_demux16

Overview:
- Write-side counterpart of the 16-way read select used in the pipeline datapath.
- Takes one store request from the LSU (select, data, byte enables) and steers it into exactly one of 16 32-bit output registers. Those registers drive LEDs, HEX displays and other memory-mapped output peripherals.
- Has a one-entry commit stage with valid/ready handshake and a freeze input.
- Provides a registered read-back port so software can load back any register.

Parameters:
- DATA_W, 32, width of each output register and of the write/read data.
- RST_VAL, 32'h0000_0000, value loaded into all 16 registers on reset.
- CNT_W, 16, width of the commit counter.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- wr_valid_i  input  1  store request present.
- wr_ready_o  output  1  block can accept a request this cycle.
- wr_sel_i  input  4  destination register index 0..15.
- wr_data_i  input  DATA_W  store data.
- wr_be_i  input  4  byte enables; bit k covers data[8k+7:8k].
- freeze_i  input  1  high = hold the staged write, no commit.
- rd_sel_i  input  4  read-back register index.
- rd_data_o  output  DATA_W  registered read-back data.
- q_o  output  16*DATA_W  all registers flattened; reg n at [32n+31:32n].
- wr_done_o  output  1  one-cycle pulse in the cycle a write commits.
- commit_cnt_o  output  CNT_W  number of commits since reset, wraps.

Behaviour:
- Reset, synchronous when rst_i=1 at a clock edge:
  - all 16 regs = RST_VAL; stage empty.
  - wr_done_o=0, commit_cnt_o=0, rd_data_o=RST_VAL.
  - wr_ready_o=1 in the cycle after reset.
  - Reset overrides any request or staged write in the same cycle; a staged write is discarded, never committed.
- Handshake:
  - A transfer occurs in a cycle with wr_valid_i & wr_ready_o.
  - sel/data/be are captured into the stage at that edge.
  - Inputs are ignored when not transferring.
- Stage (one entry, bit stg_vld):
  - Commit condition: stg_vld & !freeze_i.
  - On commit at edge t: reg[stg_sel] byte k takes stg_data byte k where stg_be[k]=1; unselected regs and unenabled bytes hold.
  - wr_done_o=1 for the cycle after edge t, then 0.
  - commit_cnt_o increments by 1 at edge t, modulo 2^CNT_W (0xFFFF -> 0x0000).
  - be=4'b0000 still commits: no data change, still pulses wr_done_o and counts.
- wr_ready_o = !stg_vld | !freeze_i (combinational):
  - Full throughput: new capture and commit of the old entry in the same edge, 1 write/cycle.
  - Stage full with freeze_i=1 -> wr_ready_o=0; request must hold until ready.
- Write latency: request accepted at edge t is visible on q_o after edge t+1 (freeze low).
- Read-back:
  - rd_data_o at edge t+1 = reg[rd_sel_i sampled at edge t] including any commit at that same edge (write-first bypass).
  - Read latency 1 cycle; reads never stall.
- freeze_i only blocks commits; it never alters register contents.
- No out-of-range sel is possible: all 16 indices are valid.

Test Plan:
- Reset then idle -> q_o all 0, rd_data_o=0, wr_ready_o=1, commit_cnt_o=0, wr_done_o=0.
- Write sel=5, data=0xDEADBEEF, be=4'hF, freeze=0 -> two edges later reg5=0xDEADBEEF, other 15 regs 0, wr_done_o pulsed once, commit_cnt_o=1.
- Back-to-back, one per cycle, freeze=0: sel=3 data=0x11111111 then sel=3 data=0x22220000 be=4'b1100 -> reg3=0x22221111; wr_ready_o stays 1; commit_cnt_o=2.
- Freeze while staged: accept sel=7 data=0xA5A5A5A5, assert freeze_i for 4 cycles with a second request pending -> wr_ready_o=0 for those cycles, reg7 unchanged, no wr_done_o. Release -> reg7=0xA5A5A5A5, second request accepted next edge.
- Read-back bypass: rd_sel_i=9 in the same cycle reg9 commits 0x0000CAFE -> next cycle rd_data_o=0x0000CAFE, not the old value.
- Reset mid-operation: stage holds sel=2 data=0x12345678 with freeze=1, assert rst_i one cycle -> reg2=0, commit_cnt_o=0, no wr_done_o. Preload commit counter to 0xFFFF via writes -> next commit wraps to 0x0000.
